// File: rtl/argmax_sequencer.sv
// argmax_sequencer: collects serial output-layer membranes over T timesteps,
// accumulates each of the ten classes with saturation, runs one compare
// cycle through comparator_final and holds the registered winner until taken.

// comparator_final: combinational 10-class argmax split into two sections.
// Ties go to the lower index inside a section and to section 1 across sections.
module comparator_final #(
  parameter int BIT_WIDTH_BIG_MEMBRANE = 16
) (
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable0_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable1_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable2_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable3_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable4_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable5_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable6_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable7_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable8_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] variable9_i,
  output logic [3:0]                               winner_o,
  output logic [3:0]                               winner_section1_o,
  output logic [3:0]                               winner_section2_o,
  output logic                                     winner_binary_o
);
  localparam int W = BIT_WIDTH_BIG_MEMBRANE;

  logic signed [W-1:0] vars [10];
  logic signed [W-1:0] best1_val, best2_val;
  logic [3:0]          best1_idx, best2_idx;

  assign vars = '{variable0_i, variable1_i, variable2_i, variable3_i, variable4_i,
                  variable5_i, variable6_i, variable7_i, variable8_i, variable9_i};

  // Strict '>' scan keeps the first (lowest) index on ties in each section.
  always_comb begin
    best1_val = vars[0];
    best1_idx = 4'd0;
    best2_val = vars[5];
    best2_idx = 4'd5;
    for (int i = 1; i < 5; i++) begin
      if (vars[i] > best1_val) begin
        best1_val = vars[i];
        best1_idx = 4'(i);
      end
      if (vars[i+5] > best2_val) begin
        best2_val = vars[i+5];
        best2_idx = 4'(i + 5);
      end
    end
    winner_binary_o   = (best2_val > best1_val);
    winner_section1_o = best1_idx;
    winner_section2_o = best2_idx;
    winner_o          = winner_binary_o ? best2_idx : best1_idx;
  end
endmodule

module argmax_sequencer #(
  parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
  parameter int TIMESTEP_WIDTH         = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     start_i,
  input  logic [TIMESTEP_WIDTH-1:0]                num_timestep_i,
  input  logic                                     membrane_valid_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] membrane_i,
  output logic                                     membrane_ready_o,
  output logic                                     result_valid_o,
  input  logic                                     result_ready_i,
  output logic [3:0]                               winner_o,
  output logic [3:0]                               winner_section1_o,
  output logic [3:0]                               winner_section2_o,
  output logic                                     winner_binary_o,
  output logic                                     busy_o
);
  localparam int W  = BIT_WIDTH_BIG_MEMBRANE;
  localparam int TW = TIMESTEP_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPARE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] acc_q [10];
  logic [3:0]          idx_q;
  logic [TW-1:0]       ts_q, t_q;
  logic [3:0]          winner_q, winner_s1_q, winner_s2_q;
  logic                winner_bin_q;
  logic                clear_en, beat_en, load_win;
  logic [3:0]          cmp_winner, cmp_s1, cmp_s2;
  logic                cmp_bin;
  logic                last_beat;

  // Add at W+1 bits, then clamp to the signed W-bit range.
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  assign last_beat = (idx_q == 4'd9) && (ts_q == t_q - TW'(1));

  // Next-state and per-cycle enables; outputs below are pure state decodes.
  always_comb begin
    state_d  = state_q;
    clear_en = 1'b0;
    beat_en  = 1'b0;
    load_win = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          clear_en = 1'b1;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (membrane_valid_i) begin
          beat_en = 1'b1;
          if (last_beat) state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        load_win = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (result_ready_i) begin
          if (start_i) begin
            clear_en = 1'b1;
            state_d  = S_COLLECT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Per-class saturating accumulators, cleared when a new inference starts.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 10; i++) acc_q[i] <= '0;
    end else if (clear_en) begin
      for (int i = 0; i < 10; i++) acc_q[i] <= '0;
    end else if (beat_en) begin
      for (int i = 0; i < 10; i++)
        if (idx_q == 4'(i)) acc_q[i] <= sat_add(acc_q[i], membrane_i);
    end
  end

  // Class index / timestep counter; T latched with 0 promoted to 1.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q <= '0;
      ts_q  <= '0;
      t_q   <= '0;
    end else if (clear_en) begin
      idx_q <= '0;
      ts_q  <= '0;
      t_q   <= (num_timestep_i == '0) ? TW'(1) : num_timestep_i;
    end else if (beat_en) begin
      if (idx_q == 4'd9) begin
        idx_q <= '0;
        ts_q  <= ts_q + TW'(1);
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  comparator_final #(.BIT_WIDTH_BIG_MEMBRANE(W)) u_cmp (
    .variable0_i       (acc_q[0]),
    .variable1_i       (acc_q[1]),
    .variable2_i       (acc_q[2]),
    .variable3_i       (acc_q[3]),
    .variable4_i       (acc_q[4]),
    .variable5_i       (acc_q[5]),
    .variable6_i       (acc_q[6]),
    .variable7_i       (acc_q[7]),
    .variable8_i       (acc_q[8]),
    .variable9_i       (acc_q[9]),
    .winner_o          (cmp_winner),
    .winner_section1_o (cmp_s1),
    .winner_section2_o (cmp_s2),
    .winner_binary_o   (cmp_bin)
  );

  // Winner registers load only on the COMPARE cycle and hold otherwise.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      winner_q     <= '0;
      winner_s1_q  <= '0;
      winner_s2_q  <= '0;
      winner_bin_q <= 1'b0;
    end else if (load_win) begin
      winner_q     <= cmp_winner;
      winner_s1_q  <= cmp_s1;
      winner_s2_q  <= cmp_s2;
      winner_bin_q <= cmp_bin;
    end
  end

  assign membrane_ready_o  = (state_q == S_COLLECT);
  assign result_valid_o    = (state_q == S_DONE);
  assign busy_o            = (state_q == S_COLLECT) || (state_q == S_COMPARE);
  assign winner_o          = winner_q;
  assign winner_section1_o = winner_s1_q;
  assign winner_section2_o = winner_s2_q;
  assign winner_binary_o   = winner_bin_q;
endmodule

// File: tb/tb_argmax_sequencer.sv
// tb_argmax_sequencer: directed table, multi-cycle corner sequences and
// randomized inferences checked against an arithmetic argmax model.
module tb_argmax_sequencer;
  localparam int W  = 16;
  localparam int TW = 8;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                start_i;
  logic [TW-1:0]       num_timestep_i;
  logic                membrane_valid_i;
  logic signed [W-1:0] membrane_i;
  logic                membrane_ready_o;
  logic                result_valid_o;
  logic                result_ready_i;
  logic [3:0]          winner_o, winner_section1_o, winner_section2_o;
  logic                winner_binary_o;
  logic                busy_o;

  int n_vec  = 0;
  int n_miss = 0;
  logic signed [W-1:0] beat_q [$];
  int pulse_idx = -1;

  always #5 clk = ~clk;

  argmax_sequencer #(.BIT_WIDTH_BIG_MEMBRANE(W), .TIMESTEP_WIDTH(TW)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .num_timestep_i    (num_timestep_i),
    .membrane_valid_i  (membrane_valid_i),
    .membrane_i        (membrane_i),
    .membrane_ready_o  (membrane_ready_o),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .winner_o          (winner_o),
    .winner_section1_o (winner_section1_o),
    .winner_section2_o (winner_section2_o),
    .winner_binary_o   (winner_binary_o),
    .busy_o            (busy_o)
  );

  typedef struct {
    logic [TW-1:0] num_t;
    int            vals [10];
    bit            gaps;
    int            w, s1, s2, bin;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: running clamped sums, first maximum wins (covers tie rules).
  function automatic void model(output int w, output int s1, output int s2, output int bin);
    int acc [10];
    for (int c = 0; c < 10; c++) acc[c] = 0;
    for (int k = 0; k < beat_q.size(); k++) begin
      int v;
      v = beat_q[k];
      acc[k % 10] = acc[k % 10] + v;
      if (acc[k % 10] > 32767)  acc[k % 10] = 32767;
      if (acc[k % 10] < -32768) acc[k % 10] = -32768;
    end
    s1 = 0; for (int c = 1; c < 5;  c++) if (acc[c] > acc[s1]) s1 = c;
    s2 = 5; for (int c = 6; c < 10; c++) if (acc[c] > acc[s2]) s2 = c;
    w  = 0; for (int c = 1; c < 10; c++) if (acc[c] > acc[w])  w  = c;
    bin = (w >= 5) ? 1 : 0;
  endfunction

  task automatic start_inf(input logic [TW-1:0] t);
    @(negedge clk);
    start_i = 1'b1; num_timestep_i = t;
    @(negedge clk);
    start_i = 1'b0;
    check("start_ready", int'(membrane_ready_o), 1);
    check("start_busy", int'(busy_o), 1);
  endtask

  // Returns just after the edge that accepted the final queued beat.
  task automatic feed_beats(input bit gaps);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < beat_q.size()) begin
      @(negedge clk);
      if (guard > 3000) begin
        check("feed_timeout", i, beat_q.size());
        break;
      end
      membrane_i       = beat_q[i];
      membrane_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (i == pulse_idx) begin
        start_i = 1'b1; num_timestep_i = 8'd5;
      end else begin
        start_i = 1'b0;
      end
      rdy = membrane_ready_o;
      @(posedge clk);
      if (membrane_valid_i && rdy) i++;
      guard++;
    end
  endtask

  task automatic expect_result(input string tag, input int w, input int s1, input int s2, input int bin);
    @(negedge clk);
    membrane_valid_i = 1'b0; start_i = 1'b0;
    check({tag, "_cmp_valid"}, int'(result_valid_o), 0);
    check({tag, "_cmp_ready"}, int'(membrane_ready_o), 0);
    @(negedge clk);
    check({tag, "_valid"}, int'(result_valid_o), 1);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_winner"}, int'(winner_o), w);
    check({tag, "_sec1"}, int'(winner_section1_o), s1);
    check({tag, "_sec2"}, int'(winner_section2_o), s2);
    check({tag, "_bin"}, int'(winner_binary_o), bin);
    $display("inference %s: winner=%0d s1=%0d s2=%0d bin=%0d", tag, winner_o,
             winner_section1_o, winner_section2_o, winner_binary_o);
  endtask

  task automatic consume(input string tag, input int w);
    @(negedge clk);
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    check({tag, "_idle_valid"}, int'(result_valid_o), 0);
    check({tag, "_held_winner"}, int'(winner_o), w);
  endtask

  task automatic load_uniform(input int t_eff, input int vals [10]);
    beat_q.delete();
    for (int t = 0; t < t_eff; t++)
      for (int c = 0; c < 10; c++) beat_q.push_back(W'(vals[c]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s1, s2, bin, t_eff;
    logic [TW-1:0] t;
    int vals [10];

    tbl[0].num_t = 8'd1; tbl[0].vals = '{10, 20, 30, 40, 50, 5, 6, 7, 8, 9};
    tbl[0].gaps = 0; tbl[0].w = 4; tbl[0].s1 = 4; tbl[0].s2 = 9; tbl[0].bin = 0;
    tbl[1].num_t = 8'd3; tbl[1].vals = '{50, 50, 50, 50, 50, 50, 50, 100, 50, 50};
    tbl[1].gaps = 1; tbl[1].w = 7; tbl[1].s1 = 0; tbl[1].s2 = 7; tbl[1].bin = 1;
    tbl[2].num_t = 8'd2; tbl[2].vals = '{-32768, -32768, -32768, -32768, -32768,
                                         -32768, -32768, -32768, -32768, -32768};
    tbl[2].gaps = 0; tbl[2].w = 0; tbl[2].s1 = 0; tbl[2].s2 = 5; tbl[2].bin = 0;
    tbl[3].num_t = 8'd2; tbl[3].vals = '{-32768, -32768, -32768, -32768, -32768,
                                         -32768, -1, -32768, -32768, -32768};
    tbl[3].gaps = 1; tbl[3].w = 6; tbl[3].s1 = 0; tbl[3].s2 = 6; tbl[3].bin = 1;
    tbl[4].num_t = 8'd0; tbl[4].vals = '{-5, 3, 3, -2, 0, 3, 1, 3, 2, -7};
    tbl[4].gaps = 1; tbl[4].w = 1; tbl[4].s1 = 1; tbl[4].s2 = 5; tbl[4].bin = 0;
    tbl[5].num_t = 8'd1; tbl[5].vals = '{1, 2, 3, 4, 5, 6, 7, 100, 8, 9};
    tbl[5].gaps = 0; tbl[5].w = 7; tbl[5].s1 = 4; tbl[5].s2 = 7; tbl[5].bin = 1;

    reset_i = 1'b1; start_i = 1'b0; num_timestep_i = '0; membrane_valid_i = 1'b0;
    membrane_i = '0; result_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", int'(membrane_ready_o), 0);
    check("rst_valid", int'(result_valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_winner", int'(winner_o), 0);
    check("rst_sec2", int'(winner_section2_o), 0);
    reset_i = 1'b0;
    @(negedge clk);
    check("idle_ready", int'(membrane_ready_o), 0);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      t_eff = (tbl[v].num_t == 0) ? 1 : int'(tbl[v].num_t);
      load_uniform(t_eff, tbl[v].vals);
      start_inf(tbl[v].num_t);
      feed_beats(tbl[v].gaps);
      expect_result($sformatf("tbl%0d", v), tbl[v].w, tbl[v].s1, tbl[v].s2, tbl[v].bin);
      consume($sformatf("tbl%0d", v), tbl[v].w);
    end

    // Saturation with a cross-section tie at full scale.
    beat_q.delete();
    for (int ts = 0; ts < 4; ts++)
      for (int c = 0; c < 10; c++)
        beat_q.push_back((c == 2) ? 16'sh7000 : ((c == 8 && ts == 0) ? 16'sh7FFF : 16'sh0000));
    start_inf(8'd4);
    feed_beats(1'b1);
    expect_result("sat", 2, 2, 8, 0);

    // Hold result with ready low, then restart back-to-back.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", int'(result_valid_o), 1);
      check("hold_winner", int'(winner_o), 2);
      check("hold_sec2", int'(winner_section2_o), 8);
    end
    result_ready_i = 1'b1; start_i = 1'b1; num_timestep_i = 8'd2;
    @(negedge clk);
    result_ready_i = 1'b0; start_i = 1'b0;
    check("b2b_ready", int'(membrane_ready_o), 1);
    check("b2b_valid", int'(result_valid_o), 0);
    vals = '{1, 1, 1, 9, 1, 1, 1, 1, 1, 1};
    load_uniform(2, vals);
    feed_beats(1'b0);
    expect_result("b2b", 3, 3, 5, 0);
    consume("b2b", 3);

    // Reset in the middle of collection.
    beat_q.delete();
    for (int k = 0; k < 13; k++) beat_q.push_back(16'sd100);
    start_inf(8'd2);
    feed_beats(1'b0);
    @(negedge clk);
    membrane_valid_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check("midrst_ready", int'(membrane_ready_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_valid", int'(result_valid_o), 0);
    check("midrst_winner", int'(winner_o), 0);
    check("midrst_sec1", int'(winner_section1_o), 0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("postrst_valid", int'(result_valid_o), 0);
    vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    load_uniform(1, vals);
    start_inf(8'd1);
    feed_beats(1'b0);
    expect_result("postrst", 9, 0, 9, 1);
    consume("postrst", 9);

    // Start pulsed mid-collection must not disturb index, counters or T.
    vals = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    load_uniform(1, vals);
    start_inf(8'd1);
    pulse_idx = 4;
    feed_beats(1'b0);
    pulse_idx = -1;
    expect_result("ignstart", 5, 4, 5, 1);
    consume("ignstart", 5);

    // Randomized inferences against the model.
    for (int r = 0; r < 20; r++) begin
      t = TW'($urandom_range(0, 4));
      t_eff = (t == 0) ? 1 : int'(t);
      beat_q.delete();
      for (int k = 0; k < 10 * t_eff; k++) begin
        case ($urandom_range(0, 2))
          0:       beat_q.push_back(W'($urandom_range(0, 200)) - 16'sd100);
          1:       beat_q.push_back(W'($urandom));
          default: beat_q.push_back(($urandom_range(0, 1) != 0) ? 16'sh7F00 : 16'sh8100);
        endcase
      end
      model(w, s1, s2, bin);
      start_inf(t);
      feed_beats($urandom_range(0, 1) != 0);
      expect_result($sformatf("rnd%0d", r), w, s1, s2, bin);
      consume($sformatf("rnd%0d", r), w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/argmax_sequencer.md
# argmax_sequencer

Sequencing controller for the 10-class output-layer argmax comparator (`comparator_final`, instantiated inside this block). It accepts output-neuron membrane values serially over a valid/ready stream, across a programmable number of timesteps. It accumulates each class with saturation into ten registers, then drives the comparator and holds a registered winner until the downstream consumer takes it. It sits between the output-layer neuron core and the result/readout interface.

## Interface
- `BIT_WIDTH_BIG_MEMBRANE`, 16: width of input membranes, accumulators and comparator operands (signed).
- `TIMESTEP_WIDTH`, 8: width of the timestep-count input.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start a new inference; sampled only in IDLE, or in DONE on the cycle the result is taken.
- `num_timestep_i`  in  TIMESTEP_WIDTH  timesteps per inference, latched on accepted start; 0 is treated as 1.
- `membrane_valid_i`  in  1  input beat valid.
- `membrane_i`  in  BIT_WIDTH_BIG_MEMBRANE  signed membrane of current class/timestep.
- `membrane_ready_o`  out  1  high only in COLLECT.
- `result_valid_o`  out  1  high in DONE.
- `result_ready_i`  in  1  consumer accepts result.
- `winner_o`  out  4  overall winning class, 0–9.
- `winner_section1_o`  out  4  winner among classes 0–4.
- `winner_section2_o`  out  4  winner among classes 5–9.
- `winner_binary_o`  out  1  0 if the overall winner is in section 1, 1 if in section 2.
- `busy_o`  out  1  high in COLLECT or COMPARE.

## Operation
- **FSM states:** IDLE, COLLECT, COMPARE, DONE.
- **IDLE:**
  - On `start_i`: clear all ten accumulators to 0, zero the class index and timestep counter, and latch `max(num_timestep_i,1)` into T.
  - Next state is COLLECT.
- **COLLECT:** a beat is accepted when `membrane_valid_i && membrane_ready_o`.
  - Beat order: class 0..9 for timestep 0, then class 0..9 for timestep 1, and so on.
  - The class index wraps 9→0 and the timestep counter increments on each wrap.
  - Accumulate: `acc[idx] <= sat(acc[idx] + membrane_i)`.
  - The add is done at BIT_WIDTH_BIG_MEMBRANE+1 bits, then clamped to [−2^(W−1), 2^(W−1)−1].
  - On the accepted beat with idx=9 and timestep=T−1, go to COMPARE.
  - Cycles without valid leave all state unchanged.
- **COMPARE:** one cycle.
  - The accumulators feed the comparator's `variable0_i..variable9_i`.
  - Register the comparator outputs into `winner_o`, `winner_section1_o`, `winner_section2_o` and `winner_binary_o`.
  - Next state is DONE.
- **DONE:**
  - Outputs are held stable while `result_valid_o` is high.
  - On `result_ready_i`: go to IDLE, or directly into COLLECT (with clear and latch as in IDLE) if `start_i` is also high.
- **Tie rule (comparator semantics):** the lower index wins within a section; section 1 wins over section 2 on equal values.
- `start_i` in COLLECT or COMPARE is ignored.
- Winner registers keep their last value outside DONE. Only the DONE-entry cycle updates them.

## Timing
- **Reset values:** state IDLE. `membrane_ready_o`, `result_valid_o`, `busy_o` = 0. All winner outputs = 0. Accumulators, index and counters = 0.
- **Reset mid-operation:** immediate return to IDLE. Any partial accumulation is discarded and no result is produced.
- **Start latency:** start accepted at edge k → `membrane_ready_o` = 1 from cycle k+1.
- **Result latency:** final beat accepted at edge n → COMPARE in cycle n+1 → `result_valid_o` = 1 from cycle n+2.
- **Minimum inference:** 1 (start) + 10·T beats + 1 (compare) cycles before valid; back-to-back inferences have zero idle cycles when start and result_ready coincide.
- `membrane_ready_o` and `result_valid_o` are registered-state decodes: no combinational path from any input.

## Test plan
- **Basic argmax:** T=1, beats 10,20,30,40,50,5,6,7,8,9 → `winner_o`=4, section1=4, section2=9, binary=0; `result_valid_o` two cycles after the last beat.
- **Multi-timestep with stalls:** T=3, class 7 = +100 every timestep and all others +50, with random `membrane_valid_i` gaps → winner=7, binary=1, section1=0.
- **Saturation:** W=16, T=4, class 2 gets 0x7000 four times and class 8 gets 0x7FFF once → both accumulate to 0x7FFF, tie → section1=2, section2=8, winner=2 (section-1 priority). A second run with all classes at −0x8000 ×2 → no wrap, winner=0.
- **Handshake and zero timesteps:** `num_timestep_i`=0 → exactly 10 beats accepted. Hold `result_ready_i` low 5 cycles → outputs stable and valid high; on ready with start high → ready high next cycle and new T latched.
- **Reset and ignored start:** assert `reset_i` after 13 beats → all outputs 0 and IDLE immediately. `start_i` pulsed mid-COLLECT → no effect on index, counters or T.
